writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Write-side counterpart of the integer register file.
- Accepts completed results from the ALU and the load unit through valid/ready handshakes, arbitrates between them, and byte-aligns and extends load data.
- Drives the register file write port (wren, wd_reg, rdv) from a registered output stage.
- Keeps a pending-write scoreboard so decode can stall on registers with results still in flight.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count.
- AW, 5, register address width; must equal clog2(NREGS).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load data returned
- ld_ready  out  1  load result accepted this cycle
- ld_rd  in  AW  load destination register
- ld_funct3  in  3  load type
- ld_byte_off  in  2  effective address bits [1:0]
- ld_word  in  XLEN  raw aligned memory word
- iss_valid  in  1  instruction with a destination issued this cycle
- iss_rd  in  AW  destination of the issued instruction
- q_rs1  in  AW  decode source 1 query
- q_rs2  in  AW  decode source 2 query
- q_rs1_busy  out  1  rs1 has an outstanding write
- q_rs2_busy  out  1  rs2 has an outstanding write
- wren  out  1  register file write enable
- wd_reg  out  AW  register file write address
- rdv  out  XLEN  register file write data

Behaviour:
- Reset (async, rst=1):
  - wren=0, wd_reg=0, rdv=0.
  - pending[NREGS-1:0]=0.
  - Any in-flight result is dropped; no write occurs after rst deasserts until a new handshake.
- Arbitration:
  - Fixed priority, load over ALU.
  - ld_ready=1 whenever rst=0.
  - alu_ready = !ld_valid.
  - At most one transfer per cycle.
- Latency:
  - A result accepted in cycle t appears as wren=1, wd_reg, rdv in cycle t+1, for exactly one cycle.
  - With no transfer accepted, wren=0 next cycle; wd_reg and rdv hold their last values.
- x0 handling:
  - A transfer with rd=0 is accepted normally (ready as above), but wren stays 0.
  - An issue with iss_rd=0 never sets pending.
- Load extraction (combinational, before the output register):
  - funct3 000 LB: byte lane ld_byte_off, sign-extended.
  - funct3 100 LBU: same lane, zero-extended.
  - funct3 001 LH: halfword lane ld_byte_off[1], sign-extended; ld_byte_off[0] ignored.
  - funct3 101 LHU: same lane, zero-extended.
  - funct3 010 LW: full word; ld_byte_off ignored.
  - Any other funct3 is treated as LW.
- Scoreboard:
  - iss_valid with iss_rd≠0 sets pending[iss_rd] at the clock edge.
  - An accepted transfer with rd≠0 clears pending[rd] at the same edge.
  - Set and clear of the same register in one cycle: set wins (a newer instruction owns the register).
  - A transfer whose rd is not pending is still written; pending is unaffected.
- Busy query (combinational):
  - q_rsN_busy = (q_rsN≠0) & (pending[q_rsN] | (wren & wd_reg==q_rsN)).
  - The wren term covers the cycle in which the register file is being written.
  - x0 is never busy.

Decomposition:
- Shared package rv_pkg:
  - XLEN and AW constants.
  - load funct3 enum (LB, LH, LW, LBU, LHU).
  - reg_addr_t and xlen_t typedefs.
- One combinational sub-module: load_extract (inputs funct3, byte_off, word; output xlen_t).
- Arbitration, output register and scoreboard stay in writeback_unit.

Test Plan:
1. Reset, then rst=0; drive alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1; next cycle wren=1, wd_reg=5, rdv=0xDEADBEEF; the cycle after, wren=0.
2. ld_word=0x80FF7F01; LB off=3 -> rdv=0xFFFFFF80; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF; LHU off=3 -> 0x000080FF; LW off=1 -> 0x80FF7F01.
3. ALU and load valid together (alu_rd=3, ld_rd=4) -> cycle t: ld_ready=1, alu_ready=0; t+1: wd_reg=4; ALU held valid is accepted at t+1; t+2: wd_reg=3.
4. iss_valid=1, iss_rd=7 -> q_rs1=7 busy=1 from the next cycle; ALU rd=7 accepted at t -> busy stays 1 at t+1 (wren term), 0 at t+2. Same-cycle issue rd=7 and accept rd=7 -> pending[7]=1 afterwards.
5. ALU rd=0 value 0x1234 -> accepted, wren never 1; iss_rd=0 -> q_rs1=0 busy=0.
6. Assert rst in the cycle after accepting rd=9 with pending[9] set -> wren=0 immediately, pending[9]=0, no write of rd=9 after release.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the integer writeback path.
//   XLEN        : datapath width
//   AW          : register address width
//   xlen_t      : one datapath word
//   reg_addr_t  : one architectural register address
//   ld_funct3_e : load type encodings carried in funct3
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [AW-1:0]   reg_addr_t;

  // Load widths and signedness as encoded in the funct3 field
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/load_extract.sv
// ---------------------------------------------------------------------------
// load_extract
// Picks the addressed byte or halfword out of a raw aligned memory word and
// sign- or zero-extends it to a full register value.  Purely combinational.
//   funct3_i   : load type (LB/LH/LW/LBU/LHU; any other value acts as LW)
//   byte_off_i : effective address bits [1:0]
//   word_i     : raw aligned memory word
//   data_o     : value to be written to the destination register
// ---------------------------------------------------------------------------
module load_extract
  import rv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] byte_off_i,
  input  xlen_t      word_i,
  output xlen_t      data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword loads only look at the upper offset bit; the lower bit of a
  // misaligned halfword address is simply ignored.
  always_comb begin
    byte_lane = word_i[8*byte_off_i +: 8];
    half_lane = word_i[16*byte_off_i[1] +: 16];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      LB:      data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LBU:     data_o = {{(XLEN-8){1'b0}}, byte_lane};
      LH:      data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
      LHU:     data_o = {{(XLEN-16){1'b0}}, half_lane};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Write side of the integer register file.  Collects finished results from
// the ALU and the load unit, arbitrates between them (load wins), aligns and
// extends load data, and drives the register file write port from a
// registered stage.  A pending-write scoreboard lets decode stall on
// registers whose results are still in flight.
//
// Ports:
//   clk, rst                        : clock and async active-high reset
//   alu_valid/alu_ready/alu_rd/
//   alu_data                        : ALU result handshake
//   ld_valid/ld_ready/ld_rd/
//   ld_funct3/ld_byte_off/ld_word   : load result handshake
//   iss_valid/iss_rd                : destination of an issued instruction
//   q_rs1/q_rs2, q_rs1_busy/q_rs2_busy : decode source busy queries
//   wren/wd_reg/rdv                 : register file write port
// ---------------------------------------------------------------------------
module writeback_unit
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int AW    = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,

  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_byte_off,
  input  logic [XLEN-1:0] ld_word,

  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,

  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            q_rs1_busy,
  output logic            q_rs2_busy,

  output logic            wren,
  output logic [AW-1:0]   wd_reg,
  output logic [XLEN-1:0] rdv
);

  logic [XLEN-1:0]  ld_data;
  logic             ld_accept;
  logic             alu_accept;
  logic             xfer;
  logic [AW-1:0]    xfer_rd;
  logic [XLEN-1:0]  xfer_data;

  logic             wren_q,    wren_d;
  logic [AW-1:0]    wd_reg_q,  wd_reg_d;
  logic [XLEN-1:0]  rdv_q,     rdv_d;
  logic [NREGS-1:0] pending_q, pending_d;

  load_extract u_load_extract (
    .funct3_i   (ld_funct3),
    .byte_off_i (ld_byte_off),
    .word_i     (ld_word),
    .data_o     (ld_data)
  );

  // Loads always have priority, so the load side is ready whenever the
  // unit is out of reset and the ALU is held off by any load request.
  always_comb begin
    ld_ready   = !rst;
    alu_ready  = !ld_valid;
    ld_accept  = ld_valid & ld_ready;
    alu_accept = alu_valid & alu_ready;
    xfer       = ld_accept | alu_accept;
    xfer_rd    = ld_accept ? ld_rd   : alu_rd;
    xfer_data  = ld_accept ? ld_data : alu_data;
  end

  // Output stage: an accepted transfer writes one cycle later, except x0,
  // which is consumed without a write.  Address/data hold when idle.
  always_comb begin
    wren_d   = xfer && (xfer_rd != '0);
    wd_reg_d = xfer ? xfer_rd   : wd_reg_q;
    rdv_d    = xfer ? xfer_data : rdv_q;
  end

  // Scoreboard: the set from a new issue is applied after the clear from a
  // completing transfer, so a newer writer keeps ownership of the register.
  always_comb begin
    pending_d = pending_q;
    if (xfer && (xfer_rd != '0))
      pending_d[xfer_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0))
      pending_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_q    <= 1'b0;
      wd_reg_q  <= '0;
      rdv_q     <= '0;
      pending_q <= '0;
    end else begin
      wren_q    <= wren_d;
      wd_reg_q  <= wd_reg_d;
      rdv_q     <= rdv_d;
      pending_q <= pending_d;
    end
  end

  // The wren term keeps a register busy while its value is physically being
  // written, since the register file read would still return the old value.
  always_comb begin
    q_rs1_busy = (q_rs1 != '0) && (pending_q[q_rs1] || (wren_q && (wd_reg_q == q_rs1)));
    q_rs2_busy = (q_rs2 != '0) && (pending_q[q_rs2] || (wren_q && (wd_reg_q == q_rs2)));
  end

  always_comb begin
    wren   = wren_q;
    wd_reg = wd_reg_q;
    rdv    = rdv_q;
  end

endmodule
